// File: rtl/a2d_pkg.sv
// Shared types and constants for the serial ADC interface.
// mk_cmd builds the channel-select command word that is sent in both SPI frames.
package a2d_pkg;
  typedef enum logic [2:0] {IDLE, FRAME1, GAP, FRAME2, DONE} state_e;

  localparam int FRAME_BITS = 16;
  localparam int CMD_CH_LSB = 11;
  localparam int RES_BITS   = 12;

  function automatic logic [FRAME_BITS-1:0] mk_cmd(input logic [2:0] ch);
    logic [FRAME_BITS-1:0] c;
    c = '0;
    c[CMD_CH_LSB +: 3] = ch;
    return c;
  endfunction
endpackage

// File: rtl/a2d_spi_shift.sv
// SPI frame engine: SCLK divider, 4-bit bit counter and a 16-bit shift register.
// It also times the inter-frame gap, so the top level needs no counter of its own.
module a2d_spi_shift
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  frame,
  input  logic                  gap,
  input  logic [FRAME_BITS-1:0] cmd,
  input  logic                  miso,
  output logic                  sclk,
  output logic                  mosi,
  output logic [RES_BITS-1:0]   rx,
  output logic                  frame_done,
  output logic                  gap_done
);
  localparam int CW = $clog2(SCLK_DIV);
  localparam logic [CW-1:0] LAST = CW'(SCLK_DIV - 1);
  localparam logic [CW-1:0] RISE = CW'(SCLK_DIV / 2 - 1);

  logic [CW-1:0]         cnt_q, cnt_d;
  logic [3:0]            bit_q, bit_d;
  logic [FRAME_BITS-1:0] shift_q, shift_d;
  logic                  sclk_q, sclk_d;
  logic                  mosi_q, mosi_d;
  logic                  at_rise, at_fall, last_bit;

  assign at_rise    = frame && (cnt_q == RISE);
  assign at_fall    = frame && (cnt_q == LAST);
  assign last_bit   = (bit_q == 4'd15);
  assign frame_done = at_fall && last_bit;
  assign gap_done   = gap && (cnt_q == LAST);

  // A load is the implicit SCLK fall that opens a frame, so the first MOSI bit goes out with it.
  always_comb begin
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    if (load) begin
      cnt_d   = '0;
      bit_d   = '0;
      shift_d = cmd;
      sclk_d  = 1'b0;
      mosi_d  = cmd[FRAME_BITS-1];
    end else begin
      if (frame || gap) cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      else              cnt_d = '0;
      if (at_rise) begin
        shift_d = {shift_q[FRAME_BITS-2:0], miso};
        sclk_d  = 1'b1;
      end
      // After the 16th period SCLK stays high into the gap/idle instead of falling.
      if (at_fall) begin
        bit_d = bit_q + 4'd1;
        if (!last_bit) begin
          sclk_d = 1'b0;
          mosi_d = shift_q[FRAME_BITS-1];
        end else begin
          mosi_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      sclk_q  <= 1'b1;
      mosi_q  <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign sclk = sclk_q;
  assign mosi = mosi_q;
  assign rx   = shift_q[RES_BITS-1:0];
endmodule

// File: rtl/a2d_intf.sv
// SPI master doing one two-frame conversion per strt_cnv on the 8-channel 12-bit ADC.
// Holds the conversion FSM, channel latch and the registered outputs.
module a2d_intf
  import a2d_pkg::*;
#(
  parameter int SCLK_DIV = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        strt_cnv,
  input  logic [2:0]  chnnl,
  output logic        cnv_cmplt,
  output logic [11:0] A2D_res,
  output logic        SS_n,
  output logic        SCLK,
  output logic        MOSI,
  input  logic        MISO
);
  state_e                state_q, state_d;
  logic [2:0]            ch_q, ch_d;
  logic                  cmplt_q, cmplt_d;
  logic [RES_BITS-1:0]   res_q, res_d;
  logic                  ss_n_q, ss_n_d;
  logic                  load, frame, gap, frame_done, gap_done, accept;
  logic [RES_BITS-1:0]   rx;

  a2d_spi_shift #(.SCLK_DIV(SCLK_DIV)) u_shift (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .frame      (frame),
    .gap        (gap),
    .cmd        (mk_cmd(ch_d)),
    .miso       (MISO),
    .sclk       (SCLK),
    .mosi       (MOSI),
    .rx         (rx),
    .frame_done (frame_done),
    .gap_done   (gap_done)
  );

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (strt_cnv)   state_d = FRAME1;
      FRAME1:  if (frame_done) state_d = GAP;
      GAP:     if (gap_done)   state_d = FRAME2;
      FRAME2:  if (frame_done) state_d = DONE;
      DONE:                    state_d = IDLE;
      default:                 state_d = IDLE;
    endcase
  end

  // cmd is built from ch_d so the first frame carries the channel presented with strt_cnv.
  always_comb begin
    accept  = (state_q == IDLE) && strt_cnv;
    frame   = (state_q == FRAME1) || (state_q == FRAME2);
    gap     = (state_q == GAP);
    load    = accept || gap_done;
    ch_d    = ch_q;
    cmplt_d = cmplt_q;
    res_d   = res_q;
    if (accept) begin
      ch_d    = chnnl;
      cmplt_d = 1'b0;
    end
    if (state_q == DONE) begin
      res_d   = rx;
      cmplt_d = 1'b1;
    end
    ss_n_d = !((state_d == FRAME1) || (state_d == FRAME2));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ch_q    <= '0;
      cmplt_q <= 1'b0;
      res_q   <= '0;
      ss_n_q  <= 1'b1;
    end else begin
      ch_q    <= ch_d;
      cmplt_q <= cmplt_d;
      res_q   <= res_d;
      ss_n_q  <= ss_n_d;
    end
  end

  assign cnv_cmplt = cmplt_q;
  assign A2D_res   = res_q;
  assign SS_n      = ss_n_q;
endmodule

// File: tb/tb_a2d_intf.sv
// Scoreboard bench for a2d_intf: a behavioural ADC slave feeds MISO and captures MOSI,
// the driver queues expected results, and a negedge monitor checks them on completion.
module tb_a2d_intf;
  localparam int D = 32;

  typedef struct {
    logic [15:0] cmd;
    logic [11:0] res;
    int          t0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst, strt_cnv, cnv_cmplt, SS_n, SCLK, MOSI;
  logic        miso = 1'b0;
  logic [2:0]  chnnl;
  logic [11:0] A2D_res;
  logic        strt4, cmplt4, ss4, sclk4, mosi4;
  logic        miso4 = 1'b1;
  logic [2:0]  chnnl4;
  logic [11:0] res4;

  a2d_intf #(.SCLK_DIV(D)) dut (
    .clk(clk), .rst(rst), .strt_cnv(strt_cnv), .chnnl(chnnl), .cnv_cmplt(cnv_cmplt),
    .A2D_res(A2D_res), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(miso)
  );

  a2d_intf #(.SCLK_DIV(4)) dut4 (
    .clk(clk), .rst(rst), .strt_cnv(strt4), .chnnl(chnnl4), .cnv_cmplt(cmplt4),
    .A2D_res(res4), .SS_n(ss4), .SCLK(sclk4), .MOSI(mosi4), .MISO(miso4)
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  exp_t        sb[$];
  logic [15:0] f1, f2;
  int          t4;
  logic        done;

  // ADC slave model: presents MISO MSB-first, advancing on each SCLK fall; captures MOSI on rises.
  logic [15:0] mosi_cap [2];
  logic [15:0] dat;
  int          fidx = 0, cur = 0, bitn = 15;
  logic        ss_p = 1'b1, sclk_p = 1'b1;
  always @(negedge clk) begin
    if (rst) fidx = 0;
    else begin
      if (!SS_n && ss_p) begin
        cur = fidx; fidx = 1 - fidx; bitn = 15;
        mosi_cap[cur] = '0;
        dat  = (cur == 0) ? f1 : f2;
        miso = dat[bitn];
      end else if (!SS_n && !SCLK && sclk_p && bitn > 0) begin
        bitn = bitn - 1;
        miso = dat[bitn];
      end
      if (!SS_n && SCLK && !sclk_p) mosi_cap[cur] = {mosi_cap[cur][14:0], MOSI};
    end
    ss_p = SS_n; sclk_p = SCLK;
  end

  // Monitor / scoreboard
  int   checks = 0, errors = 0, k, r4 = 0, lr4 = 0;
  logic rst_chk = 1'b0, cmplt_p = 1'b0, cmplt4_p = 1'b0, sclk4_p = 1'b1;
  exp_t e;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      sb.delete();
      rst_chk = 1'b1;
    end else begin
      if (rst_chk) begin
        chk("rst_ss_n", SS_n, 1); chk("rst_sclk", SCLK, 1); chk("rst_mosi", MOSI, 0);
        chk("rst_cmplt", cnv_cmplt, 0); chk("rst_res", A2D_res, 0);
        rst_chk = 1'b0;
      end
      if (sb.size() != 0) begin
        k = cyc - sb[0].t0;
        case (k)
          1:        begin chk("ss_fall", SS_n, 0); chk("cmplt_clr", cnv_cmplt, 0); end
          16:       chk("sclk_low", SCLK, 0);
          17:       chk("sclk_rise", SCLK, 1);
          512:      chk("ss_f1_end", SS_n, 0);
          513, 544: chk("ss_gap", SS_n, 1);
          545:      begin chk("ss_f2", SS_n, 0); chk("sclk_f2", SCLK, 0); end
          default: ;
        endcase
      end
      if (cnv_cmplt === 1'b1 && cmplt_p !== 1'b1) begin
        if (sb.size() == 0) chk("cmplt_pending", 0, 1);
        else begin
          e = sb.pop_front();
          chk("a2d_res", A2D_res, e.res);
          chk("mosi_f1", mosi_cap[0], e.cmd);
          chk("mosi_f2", mosi_cap[1], e.cmd);
          chk("latency", cyc - e.t0 - 1, 33 * D + 1);
        end
      end
      if (sclk4 === 1'b1 && sclk4_p === 1'b0 && ss4 === 1'b0) begin
        if (r4 % 16 != 0) chk("sclk4_spacing", cyc - lr4, 4);
        r4++; lr4 = cyc;
      end
      if (cmplt4 === 1'b1 && cmplt4_p !== 1'b1) begin
        chk("d4_rises", r4, 32);
        chk("d4_res", res4, 12'hFFF);
        chk("d4_latency", cyc - t4 - 1, 133);
      end
      if (done) begin
        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
      end
    end
    cmplt_p = cnv_cmplt; cmplt4_p = cmplt4; sclk4_p = sclk4;
  end

  // Driver
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] ch, input logic [15:0] d1, input logic [15:0] d2,
                       input logic [15:0] cmd);
    exp_t x;
    f1 = d1; f2 = d2;
    chnnl = ch; strt_cnv = 1'b1;
    x.cmd = cmd; x.res = d2[11:0]; x.t0 = cyc;
    sb.push_back(x);
    tick(1);
    strt_cnv = 1'b0;
  endtask

  task automatic wait_cmplt();
    for (int i = 0; i < 2000; i++) begin
      if (cnv_cmplt === 1'b1) return;
      tick(1);
    end
    $display("FAIL wait_cmplt: got timeout expected cnv_cmplt within 2000 cycles");
    $fatal(1, "conversion never completed");
  endtask

  initial begin
    rst = 1'b1; strt_cnv = 1'b0; chnnl = '0; f1 = '0; f2 = '0;
    strt4 = 1'b0; chnnl4 = '0; done = 1'b0; t4 = 0;
    tick(3); rst = 1'b0; tick(2);

    strt4 = 1'b1; chnnl4 = 3'd6; t4 = cyc; tick(1); strt4 = 1'b0;

    issue(3'd3, 16'h1234, 16'h0ABC, 16'h1800); wait_cmplt(); tick(3);
    issue(3'd7, 16'h0000, 16'hFFFF, 16'h3800); wait_cmplt(); tick(3);

    // requests during a conversion must be ignored
    issue(3'd2, 16'hF0F0, 16'h0123, 16'h1000);
    tick(99);  strt_cnv = 1'b1; chnnl = 3'd5; tick(1); strt_cnv = 1'b0;
    tick(499); strt_cnv = 1'b1; chnnl = 3'd5; tick(1); strt_cnv = 1'b0;
    wait_cmplt(); tick(3);

    // back-to-back: restart in the first cycle cnv_cmplt is high
    issue(3'd1, 16'h5555, 16'h0456, 16'h0800); wait_cmplt();
    issue(3'd6, 16'hAAAA, 16'h0789, 16'h3000); wait_cmplt(); tick(3);

    // reset mid FRAME1, then a normal conversion
    issue(3'd4, 16'h1111, 16'h0FED, 16'h2000);
    tick(299); rst = 1'b1; tick(1); rst = 1'b0; tick(3);
    issue(3'd5, 16'h2222, 16'h0DEF, 16'h2800); wait_cmplt(); tick(5);

    done = 1'b1;
    tick(10);
  end
endmodule
